// File: rtl/s1_dist.sv
// s1_dist: registered 1-to-4 distributor with per-channel valid flags,
// read strobes, round-robin auto-steering and sticky overflow detection.
//
// Ports:
//   clk      rising-edge clock
//   CLR      asynchronous active-low reset
//   D        data word to distribute (size bits)
//   A1/B1/A0 channel select, channel = {(A1|B1), A0}
//   LD       load request
//   AUTO     1 = steer by internal pointer, 0 = steer by A1/B1/A0
//   RD       per-channel read/acknowledge strobe
//   OVF_CLR  synchronous clear of the sticky overflow flag
//   Q0..Q3   channel holding registers
//   V        per-channel valid flags
//   OVF      sticky overflow (a load was dropped)
//   ptr      round-robin pointer
//   drop_cnt saturating drop counter (only with S1_DIST_DROPCNT_EN)
//
// Optional feature macro: S1_DIST_DROPCNT_EN adds drop_cnt [7:0].
module s1_dist #(
  parameter int size = 5
) (
  input  logic            clk,
  input  logic            CLR,
  input  logic [size-1:0] D,
  input  logic            A1,
  input  logic            B1,
  input  logic            A0,
  input  logic            LD,
  input  logic            AUTO,
  input  logic [3:0]      RD,
  input  logic            OVF_CLR,
  output logic [size-1:0] Q0,
  output logic [size-1:0] Q1,
  output logic [size-1:0] Q2,
  output logic [size-1:0] Q3,
  output logic [3:0]      V,
`ifdef S1_DIST_DROPCNT_EN
  output logic [7:0]      drop_cnt,
`endif
  output logic            OVF,
  output logic [1:0]      ptr
);

  logic [size-1:0] q_q [4];
  logic [size-1:0] q_d [4];
  logic [3:0]      v_q, v_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      ptr_q, ptr_d;

  logic [1:0] sel;
  logic       accept;
  logic       drop;

  assign sel    = AUTO ? ptr_q : {(A1 | B1), A0};
  // A full channel still accepts when it is read in the same cycle.
  assign accept = LD & (~v_q[sel] | RD[sel]);
  assign drop   = LD & v_q[sel] & ~RD[sel];

  always_comb begin
    q_d = q_q;
    v_d = v_q;
    for (int i = 0; i < 4; i++) begin
      if (accept && (sel == 2'(i))) begin
        q_d[i] = D;
        v_d[i] = 1'b1;
      end else if (RD[i]) begin
        v_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (AUTO && accept)
      ptr_d = ptr_q + 2'd1;
  end

  // Set wins over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (OVF_CLR)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < 4; i++)
        q_q[i] <= '0;
      v_q   <= 4'b0000;
      ovf_q <= 1'b0;
      ptr_q <= 2'b00;
    end else begin
      q_q   <= q_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
      ptr_q <= ptr_d;
    end
  end

`ifdef S1_DIST_DROPCNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Clear restarts the count, keeping a drop seen in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (OVF_CLR)
      cnt_d = drop ? 8'd1 : 8'd0;
    else if (drop && (cnt_q != 8'hFF))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR)
      cnt_q <= 8'd0;
    else
      cnt_q <= cnt_d;
  end

  assign drop_cnt = cnt_q;
`endif

  assign Q0  = q_q[0];
  assign Q1  = q_q[1];
  assign Q2  = q_q[2];
  assign Q3  = q_q[3];
  assign V   = v_q;
  assign OVF = ovf_q;
  assign ptr = ptr_q;

endmodule

// File: tb/tb_s1_dist.sv
// tb_s1_dist: table-driven directed test of s1_dist plus hand-written
// sequences for asynchronous reset and the optional drop counter.
module tb_s1_dist;

  logic       clk = 1'b0;
  logic       CLR;
  logic [4:0] D;
  logic       A1, B1, A0, LD, AUTO, OVF_CLR;
  logic [3:0] RD;
  logic [4:0] Q0, Q1, Q2, Q3;
  logic [3:0] V;
  logic       OVF;
  logic [1:0] ptr;
`ifdef S1_DIST_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  s1_dist #(.size(5)) dut (
    .clk     (clk),
    .CLR     (CLR),
    .D       (D),
    .A1      (A1),
    .B1      (B1),
    .A0      (A0),
    .LD      (LD),
    .AUTO    (AUTO),
    .RD      (RD),
    .OVF_CLR (OVF_CLR),
    .Q0      (Q0),
    .Q1      (Q1),
    .Q2      (Q2),
    .Q3      (Q3),
    .V       (V),
`ifdef S1_DIST_DROPCNT_EN
    .drop_cnt(drop_cnt),
`endif
    .OVF     (OVF),
    .ptr     (ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       au;
    logic       a1;
    logic       b1;
    logic       a0;
    logic [4:0] d;
    logic [3:0] rd;
    logic       oc;
    logic [4:0] q0;
    logic [4:0] q1;
    logic [4:0] q2;
    logic [4:0] q3;
    logic [3:0] v;
    logic       ovf;
    logic [1:0] p;
  } vec_t;

  vec_t tv [17];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] pack_out();
    return {5'd0, Q0, Q1, Q2, Q3, V, OVF, ptr};
  endfunction

  function automatic logic [31:0] pack_exp(input vec_t t);
    return {5'd0, t.q0, t.q1, t.q2, t.q3, t.v, t.ovf, t.p};
  endfunction

  task automatic drive(input logic ld, input logic au, input logic a1,
                       input logic b1, input logic a0, input logic [4:0] d,
                       input logic [3:0] rd, input logic oc);
    LD = ld; AUTO = au; A1 = a1; B1 = b1; A0 = a0;
    D = d; RD = rd; OVF_CLR = oc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         ld au a1 b1 a0 d   rd       oc q0 q1 q2 q3 v        ovf p
    tv[0]  = '{1, 0, 0, 0, 0, 3,  4'b0000, 0, 3, 0, 0, 0, 4'b0001, 0, 0};
    tv[1]  = '{1, 0, 1, 0, 1, 9,  4'b0000, 0, 3, 0, 0, 9, 4'b1001, 0, 0};
    tv[2]  = '{1, 0, 0, 1, 0, 17, 4'b0000, 0, 3, 0, 17, 9, 4'b1101, 0, 0};
    tv[3]  = '{0, 0, 1, 1, 1, 31, 4'b1111, 0, 3, 0, 17, 9, 4'b0000, 0, 0};
    tv[4]  = '{1, 1, 0, 0, 0, 1,  4'b0000, 0, 1, 0, 17, 9, 4'b0001, 0, 1};
    tv[5]  = '{1, 1, 0, 0, 0, 2,  4'b0000, 0, 1, 2, 17, 9, 4'b0011, 0, 2};
    tv[6]  = '{1, 1, 0, 0, 0, 3,  4'b0000, 0, 1, 2, 3, 9, 4'b0111, 0, 3};
    tv[7]  = '{1, 1, 0, 0, 0, 4,  4'b0000, 0, 1, 2, 3, 4, 4'b1111, 0, 0};
    tv[8]  = '{1, 1, 0, 0, 0, 5,  4'b0000, 0, 1, 2, 3, 4, 4'b1111, 1, 0};
    tv[9]  = '{1, 0, 0, 0, 1, 12, 4'b0010, 1, 1, 12, 3, 4, 4'b1111, 0, 0};
    tv[10] = '{0, 0, 0, 0, 0, 0,  4'b0010, 0, 1, 12, 3, 4, 4'b1101, 0, 0};
    tv[11] = '{1, 0, 0, 0, 0, 30, 4'b0000, 1, 1, 12, 3, 4, 4'b1101, 1, 0};
    tv[12] = '{0, 0, 0, 0, 0, 0,  4'b0000, 1, 1, 12, 3, 4, 4'b1101, 0, 0};
    tv[13] = '{1, 1, 1, 1, 1, 7,  4'b0001, 0, 7, 12, 3, 4, 4'b1101, 0, 1};
    tv[14] = '{1, 1, 0, 0, 0, 8,  4'b0000, 0, 7, 8, 3, 4, 4'b1111, 0, 2};
    tv[15] = '{1, 0, 1, 1, 0, 21, 4'b1000, 0, 7, 8, 3, 4, 4'b0111, 1, 2};
    tv[16] = '{0, 0, 0, 0, 0, 0,  4'b0010, 1, 7, 8, 3, 4, 4'b0101, 0, 2};

    drive(0, 0, 0, 0, 0, 0, 4'b0000, 0);
    CLR = 1'b0;
    #12;
    check("reset_state", pack_out(), 32'd0);
`ifdef S1_DIST_DROPCNT_EN
    check("reset_cnt", {24'd0, drop_cnt}, 32'd0);
`endif
    @(negedge clk);
    CLR = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tv[i].ld, tv[i].au, tv[i].a1, tv[i].b1, tv[i].a0,
            tv[i].d, tv[i].rd, tv[i].oc);
      step();
      check($sformatf("vec%0d", i), pack_out(), pack_exp(tv[i]));
    end

    // Asynchronous reset mid-cycle, no clock edge involved.
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 9, 4'b0000, 0);
    #2 CLR = 1'b0;
    #1;
    check("async_reset", pack_out(), 32'd0);
    step();
    check("reset_held", pack_out(), 32'd0);
    @(negedge clk);
    CLR = 1'b1;
    drive(0, 0, 1, 0, 1, 22, 4'b1111, 1);
    step();
    check("post_reset_idle", pack_out(), 32'd0);

`ifdef S1_DIST_DROPCNT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 1, 0, 0, 0, 5'(i + 1), 4'b0000, 0);
      step();
    end
    check("cnt_fill_v", {28'd0, V}, 32'hF);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 5'd9, 4'b0000, 0);
    step();
    check("cnt_first", {24'd0, drop_cnt}, 32'd1);
    for (int i = 0; i < 299; i++) step();
    check("cnt_sat", {24'd0, drop_cnt}, 32'hFF);
    @(negedge clk);
    OVF_CLR = 1'b1;
    step();
    check("cnt_clr_drop", {24'd0, drop_cnt}, 32'd1);
    check("cnt_ovf", {31'd0, OVF}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/s1_dist.md
Name: s1_dist

Overview:
- Registered 1-to-4 distributor; the write-side counterpart of the S-module mux/flop cell.
- One data word, steered by the same select encoding (A1, B1, A0), is loaded into one of four holding registers.
- Each register carries a valid flag; a per-channel read strobe frees it.
- Round-robin auto-steering mode and sticky overflow detection included.

Parameters:
- size, 5, width of data word and each output register.

Ports:
- clk  input  1  rising-edge clock
- CLR  input  1  asynchronous reset, active-low
- D  input  size  data word to distribute
- A1  input  1  select high term (OR'd with B1)
- B1  input  1  select high term (OR'd with A1)
- A0  input  1  select low bit
- LD  input  1  load request, sampled at posedge clk
- AUTO  input  1  1 = steer by internal pointer, 0 = steer by A1/B1/A0
- RD  input  4  per-channel read/acknowledge strobe
- OVF_CLR  input  1  synchronous clear of sticky overflow
- Q0..Q3  output  size each  channel holding registers
- V  output  4  per-channel valid flags
- OVF  output  1  sticky overflow (a load was dropped)
- ptr  output  2  round-robin pointer

Behaviour:
- Reset (CLR=0, asynchronous, any time including mid-transfer):
  - Q0..Q3=0, V=4'b0000, OVF=0, ptr=2'b00; drop_cnt=0 when the optional feature is present.
  - Held while CLR=0.
- Channel select: sel = AUTO ? ptr : {(A1|B1), A0}.
  - Example: A1=0, B1=1, A0=0 -> channel 2.
- All state updates on posedge clk; outputs are registered, visible one edge after the sampling edge, no combinational paths to outputs.
- accept = LD & (~V[sel] | RD[sel]).
  - On accept: Q[sel] <= D, V[sel] <= 1.
  - Accept on a full channel with RD[sel]=1 in the same cycle: Q[sel] overwritten, V[sel] stays 1 (read and write both honoured).
- drop = LD & V[sel] & ~RD[sel].
  - Q[sel] and V[sel] unchanged; OVF <= 1; ptr unchanged.
- Read: RD[i]=1, V[i]=1, and no accept on channel i -> V[i] <= 0, Q[i] retains its value.
  - RD[i] with V[i]=0 is ignored.
  - Any combination of RD bits is allowed in one cycle.
- Pointer:
  - AUTO=1 and accept -> ptr <= ptr+1 mod 4 (3 wraps to 0).
  - Otherwise ptr holds; manual mode never moves ptr.
  - Switching AUTO mid-stream takes effect on the next sampling edge; ptr keeps its value.
- OVF:
  - Sticky; cleared only by OVF_CLR=1 (synchronous) or reset.
  - drop and OVF_CLR in the same cycle -> OVF=1 (set wins).
- LD=0: select inputs and D are don't-care; no state change except reads and OVF_CLR.
- Throughput: one load per clock.

Optional Feature:
- Macro S1_DIST_DROPCNT_EN.
- Defined:
  - Adds output drop_cnt [7:0], reset 0.
  - Increments on every drop; saturates at 8'hFF.
  - Cleared by OVF_CLR (same cycle as a drop -> drop_cnt = 1).
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset: CLR=0 mid-stream with V=4'b1011 -> immediately Q0..Q3=0, V=0, OVF=0, ptr=0; after release with LD=0 everything stays 0.
2. Manual steering: AUTO=0; LD with (A1,B1,A0)=(0,0,0),D=5'd3; then (1,0,1),D=5'd9; then (0,1,0),D=5'd17 -> Q0=3, Q3=9, Q2=17, V=4'b1101, ptr=0.
3. Round-robin: AUTO=1, LD held 4 cycles, D=1,2,3,4, RD=0 from empty -> Q0..Q3=1,2,3,4, V=4'b1111, ptr wraps to 0. A 5th LD with D=5 -> dropped, Q0 stays 1, OVF=1, ptr stays 0.
4. Simultaneous read/write: V[1]=1, Q1=7; LD to ch1 with D=12 and RD=4'b0010 same cycle -> Q1=12, V[1]=1, OVF=0. Next cycle RD=4'b0010 only -> V[1]=0, Q1=12.
5. OVF priority: OVF=1; drop and OVF_CLR=1 same cycle -> OVF=1. Next cycle OVF_CLR=1 alone -> OVF=0.
6. With S1_DIST_DROPCNT_EN: 300 consecutive drops -> drop_cnt=8'hFF. OVF_CLR with a concurrent drop -> drop_cnt=1.
